// File: rtl/synth_audio_pkg.sv
// Shared audio-path constants and the 16-bit output saturator.
package synth_audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int TONE_W     = 32;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  localparam logic signed [TONE_W-1:0] T_MAX = 32'sd32767;
  localparam logic signed [TONE_W-1:0] T_MIN = -32'sd32768;

  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [TONE_W-1:0] t);
    if (t > T_MAX)      return SAT_MAX;
    else if (t < T_MIN) return SAT_MIN;
    else                return t[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample handshake between the note-iteration FSM and the DAC output stage.
interface i2s_dac_tx_if;
  import synth_audio_pkg::*;
  logic [TONE_W-1:0] SAMPLE_IN;
  logic              SAMPLE_VALID;
  logic              SAMPLE_REQ;

  modport master (output SAMPLE_IN, output SAMPLE_VALID, input SAMPLE_REQ);
  modport slave  (input SAMPLE_IN, input SAMPLE_VALID, output SAMPLE_REQ);
endinterface

// File: rtl/i2s_frame_timer.sv
// BCLK divider and 64-bit frame position counter; strobes are combinational
// so the consumer can update its outputs on the same edge BCLK falls.
module i2s_frame_timer
  import synth_audio_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             o_bclk,
  output logic             o_fall,
  output logic             o_frame,
  output logic [BIT_W-1:0] o_bit_cnt
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0]    r_div;
  logic             r_bclk;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             w_wrap;

  assign w_wrap    = (r_div == DW'(BCLK_DIV - 1));
  assign o_fall    = w_wrap & r_bclk;
  assign o_frame   = o_fall & (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign o_bclk    = r_bclk;
  assign o_bit_cnt = r_bit_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div     <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= BIT_W'(FRAME_BITS - 1);
    end else begin
      if (w_wrap) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + DW'(1);
      end
      if (o_fall) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end
endmodule

// File: rtl/i2s_dac_tx.sv
// Mono I2S DAC transmitter: captures, scales and saturates the accumulated
// tone, then serialises the same 16-bit word into both slots of each frame.
module i2s_dac_tx
  import synth_audio_pkg::*;
#(
  parameter int BCLK_DIV  = 8,
  parameter int OUT_SHIFT = 12
) (
  input  logic         CLK,
  input  logic         RESET,
  i2s_dac_tx_if.slave  sif,
  input  logic         MUTE,
  input  logic         UNDERRUN_CLR,
  output logic         UNDERRUN,
  output logic         AUD_BCLK,
  output logic         AUD_DACLRCK,
  output logic         AUD_DACDAT
);
  logic                       w_fall, w_frame;
  logic [BIT_W-1:0]           w_bit_cnt, w_b;
  logic [BIT_W-2:0]           w_p;
  logic [3:0]                 w_idx;
  logic                       w_bit;
  logic signed [TONE_W-1:0]   w_t;

  logic                r_lrck, r_dat, r_req, r_unrun, r_fresh;
  logic [SAMPLE_W-1:0] r_buf, r_shift;

  i2s_frame_timer #(.BCLK_DIV(BCLK_DIV)) u_tmr (
    .CLK       (CLK),
    .RESET     (RESET),
    .o_bclk    (AUD_BCLK),
    .o_fall    (w_fall),
    .o_frame   (w_frame),
    .o_bit_cnt (w_bit_cnt)
  );

  // Position the fall event is moving to; slot bit 0 is the I2S delay bit.
  assign w_b   = w_bit_cnt + BIT_W'(1);
  assign w_p   = w_b[BIT_W-2:0];
  assign w_idx = 4'(5'd16 - w_p);
  assign w_bit = (w_p != '0 && w_p <= 5'd16) ? r_shift[w_idx] : 1'b0;
  assign w_t   = $signed(sif.SAMPLE_IN) >>> OUT_SHIFT;

  assign sif.SAMPLE_REQ = r_req;
  assign UNDERRUN       = r_unrun;
  assign AUD_DACLRCK    = r_lrck;
  assign AUD_DACDAT     = r_dat;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_lrck  <= 1'b0;
      r_dat   <= 1'b0;
      r_req   <= 1'b0;
      r_unrun <= 1'b0;
      r_buf   <= '0;
      r_fresh <= 1'b0;
      r_shift <= '0;
    end else begin
      r_req <= w_frame;
      if (w_fall) begin
        r_lrck <= w_b[BIT_W-1];
        r_dat  <= w_bit;
      end
      // Load reads the pre-capture buffer, so a coincident strobe lands next frame.
      if (w_frame) r_shift <= MUTE ? '0 : r_buf;
      if (sif.SAMPLE_VALID) r_buf <= sat16(w_t);
      if (sif.SAMPLE_VALID) r_fresh <= 1'b1;
      else if (w_frame)     r_fresh <= 1'b0;
      if (w_frame && !r_fresh) r_unrun <= 1'b1;
      else if (UNDERRUN_CLR)   r_unrun <= 1'b0;
    end
  end
endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Audio output stage directly downstream of the per-key synthesis datapath.
- Captures the 32-bit accumulated TONE once the note-iteration FSM finishes a sample period, then scales and saturates it to signed 16 bits.
- Serialises the sample as mono (same value on L and R) in I2S format to the board codec DAC.
- Generates the frame-rate SAMPLE_REQ pulse that tells the upstream FSM to start the next accumulation pass.

Parameters:
- BCLK_DIV, 8: CLK cycles per BCLK half-period. Default at 50 MHz gives BCLK 3.125 MHz and a 48.828 kHz frame rate.
- OUT_SHIFT, 12: arithmetic right shift applied to SAMPLE_IN before 16-bit saturation.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- SAMPLE_IN  in  32  signed accumulated tone (TONE) from the datapath
- SAMPLE_VALID  in  1  one-cycle strobe; SAMPLE_IN is final for this period
- MUTE  in  1  forces transmitted data to zero at the next frame load
- UNDERRUN_CLR  in  1  clears UNDERRUN
- SAMPLE_REQ  out  1  one-cycle pulse at each frame start; request next sample
- UNDERRUN  out  1  sticky flag: a frame started with no fresh sample
- AUD_BCLK  out  1  I2S bit clock
- AUD_DACLRCK  out  1  I2S word select; 0 = left, 1 = right
- AUD_DACDAT  out  1  I2S serial data

Behaviour:
- Reset values:
  - AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN all 0.
  - div_cnt = 0, bit_cnt = 63.
  - Holding buffer = 0, fresh flag = 0, shift register = 0.
- A RESET mid-frame returns everything to these values; the next frame starts cleanly.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - At BCLK_DIV-1 it wraps and AUD_BCLK toggles.
  - A 1->0 toggle is a "fall event".
- Fall event:
  - bit_cnt <= bit_cnt+1, mod 64.
  - Let b be the new bit_cnt and p = b[4:0].
  - AUD_DACLRCK <= b[5].
  - AUD_DACDAT <= 0 if p==0 (I2S one-bit delay); shift[16-p] for p in 1..16; 0 for p>16.
  - Data and LRCK change only on BCLK falling edges.
- Frame load, on the fall event where b==0:
  - Shift register <= buffer, or 0 if MUTE.
  - SAMPLE_REQ = 1 for exactly that CLK cycle.
  - If fresh==0, set UNDERRUN; the previous buffer value is replayed.
  - fresh <= 0.
  - The same 16-bit word is reused for the right slot (b==32); no reload there.
- Capture:
  - On SAMPLE_VALID, t = SAMPLE_IN >>> OUT_SHIFT (sign-preserving).
  - buffer <= 0x7FFF if t > 32767; 0x8000 if t < -32768; else t[15:0].
  - fresh <= 1.
  - Latency: the buffer is valid one cycle after the strobe.
- Simultaneous SAMPLE_VALID and frame load:
  - The load uses the old buffer value.
  - The new value is written to the buffer and fresh ends at 1; set wins over clear.
- Multiple SAMPLE_VALID in one frame: the last one wins; no error.
- UNDERRUN:
  - Cleared by UNDERRUN_CLR.
  - A set in the same cycle wins over the clear.
- Frame period is exactly 128*BCLK_DIV CLK cycles. The first SAMPLE_REQ occurs at CLK cycle 2*BCLK_DIV after RESET deasserts.
- Upstream contract: the FSM starts the key loop on SAMPLE_REQ and must assert SAMPLE_VALID within one frame period.

Decomposition:
- Shared package synth_audio_pkg holds:
  - SAMPLE_W = 16, TONE_W = 32, SLOT_BITS = 32, FRAME_BITS = 64.
  - Saturation bounds SAT_MAX = 16'h7FFF, SAT_MIN = 16'h8000.
- Sub-module i2s_frame_timer: divider plus bit counter. It outputs AUD_BCLK, a fall strobe, bit_cnt and a frame-start strobe.
- Capture, saturation and serialisation stay in i2s_dac_tx.

Test Plan:
1. Scaling: SAMPLE_IN = 0x0012_3000 with SAMPLE_VALID before the frame -> buffer 0x0123; the left slot serialises 0,0000000100100011 then zeros; the right slot repeats the same bits.
2. Positive saturation: SAMPLE_IN = 0x0800_0000 -> 0x7FFF. Negative saturation: SAMPLE_IN = 0xF000_0000 -> 0x8000. Check 0xFFFF_F000 -> 0xFFFF, no saturation.
3. Timing:
   - SAMPLE_REQ pulses one cycle, every 1024 CLK.
   - AUD_BCLK period is 16 CLK.
   - AUD_DACLRCK toggles every 512 CLK, aligned to BCLK falling edges.
   - First SAMPLE_REQ at cycle 16 after reset.
4. Underrun: skip SAMPLE_VALID for one frame -> UNDERRUN=1 and the previous sample is replayed; UNDERRUN_CLR -> 0; a clear coincident with a new underrun -> stays 1.
5. Collision: SAMPLE_VALID on the SAMPLE_REQ cycle with 0x0000_5000 -> the current frame carries the old value, the next frame carries 0x0005, and no UNDERRUN is raised.
6. MUTE=1 at frame load -> AUD_DACDAT stays 0 for the whole frame. Assert RESET mid-frame -> all outputs return to 0 and bit_cnt to 63 in the next cycle.
